abz_quad_decoder: RTL
=====================

ABZ_QUAD_DECODER -- requirements
Module: abz_quad_decoder

Interface
REQ-001 Parameter BIT_LENGTH, default 16, width of all count/position buses.
REQ-002 Parameter FILT_LEN, default 3, cycles of stable level required by A/B/Z glitch filter; 0 = filter bypassed.
REQ-003 Clocking/reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 A_IN, B_IN, Z_IN  in  1 each  asynchronous encoder inputs.
REQ-007 MODE  in  2  decode mode: 00 = x1, 01 = x2, 1x = x4.
REQ-008 Z_MODE  in  1  0 = clear on every qualified Z; 1 = one-shot homing.
REQ-009 ARM_IN  in  1  rising edge arms one-shot homing.
REQ-010 EN_INIT_IN  in  1  rising edge loads INIT_COUNT.
REQ-011 INIT_COUNT, POS_OFFSET, CNT_MAX  in  BIT_LENGTH each  init value, value loaded at Z, wrap limit.
REQ-012 LATCH_IN  in  1  rising edge snapshots count.
REQ-013 ERR_CLR  in  1  level; clears ERR.
REQ-014 CNT_OUT  out  BIT_LENGTH  live position.
REQ-015 LATCHED_CNT_OUT  out  BIT_LENGTH; LATCH_VLD  out  1  snapshot and 1-cycle valid pulse.
REQ-016 Z_LATCHED_CNT  out  BIT_LENGTH  CNT_OUT value just before each qualified Z load.
REQ-017 DIR_OUT  out  1  last direction (1 = up); HOMED  out  1  home complete; ERR  out  1  sticky illegal transition.
REQ-018 WRAP_UP, WRAP_DN  out  1 each  1-cycle wrap pulses.

Function
REQ-019 A/B/Z SHALL pass a 2-FF synchronizer, then a filter whose output takes a new level only after FILT_LEN consecutive cycles of that level; CNT_OUT SHALL update exactly FILT_LEN+3 CLK edges after the edge first sampling a new A/B level.
REQ-020 Edges SHALL be detected on filtered A/B/Z; EN_INIT_IN, ARM_IN, LATCH_IN are synchronous, edge-detected without synchronizer.
REQ-021 x4: every A/B edge counts; up when (A rise, B=0), (B rise, A=1), (A fall, B=1), (B fall, A=0); opposite combinations down.
REQ-022 x2: only A edges count, up/down as x4 rows for A.
REQ-023 x1: up on A rise with B=0; down on A fall with B=0; other edges ignored.
REQ-024 Illegal transition (filtered A and B toggle same cycle) SHALL not count, SHALL set ERR; ERR held until ERR_CLR=1; set wins over clear in same cycle.
REQ-025 Counting range [0, CNT_MAX]: up at CNT_OUT>=CNT_MAX -> 0 with WRAP_UP pulse; down at 0 -> CNT_MAX with WRAP_DN pulse.
REQ-026 DIR_OUT SHALL update on every x4-qualified A/B edge regardless of MODE.
REQ-027 Qualified Z: filtered Z rising edge if DIR_OUT=1, falling edge if DIR_OUT=0.
REQ-028 Z_MODE=0: each qualified Z loads POS_OFFSET into CNT_OUT and CNT_OUT old value into Z_LATCHED_CNT.
REQ-029 Z_MODE=1: ARM_IN rising edge sets internal ARMED, clears HOMED; first qualified Z while ARMED loads as REQ-028, clears ARMED, sets HOMED; other Z ignored.
REQ-030 Per-cycle priority on CNT_OUT: EN_INIT_IN rise > qualified Z load > count; lower-priority event in same cycle discarded, no wrap pulse.
REQ-031 LATCH_IN rise SHALL capture CNT_OUT value of that cycle (pre-update) into LATCHED_CNT_OUT and assert LATCH_VLD for exactly the next cycle.
REQ-032 MODE/Z_MODE/CNT_MAX changes take effect next edge; no retroactive counting.

Reset
REQ-033 RST=1 at a CLK edge SHALL zero all outputs, synchronizers, filters, edge history, ARMED, DIR_OUT, regardless of operation in progress; no edge detected on first cycle after reset for inputs already high.

Verification
REQ-034 FILT_LEN=3, x4, CNT_MAX=0xFFFF: one forward Gray cycle (4 edges) -> CNT_OUT 0->4, each step 6 cycles after input edge; reverse cycle -> 0.
REQ-035 x1 vs x2 vs x4 with 10 forward cycles -> CNT_OUT 10, 20, 40.
REQ-036 CNT_MAX=99, CNT_OUT=99, one up step -> 0 and WRAP_UP pulse; down step -> 99 and WRAP_DN.
REQ-037 A 2-cycle glitch on A (FILT_LEN=3) -> no count; A and B toggled same cycle -> ERR=1, count unchanged, ERR_CLR -> 0.
REQ-038 Z_MODE=1, POS_OFFSET=500, CNT_OUT=1234, ARM_IN pulse then qualified Z -> CNT_OUT=500, Z_LATCHED_CNT=1234, HOMED=1; second Z ignored.
REQ-039 EN_INIT_IN rise with qualified Z and count edge same cycle -> CNT_OUT=INIT_COUNT; LATCH_IN rise -> LATCHED_CNT_OUT valid with LATCH_VLD one cycle.

Source files
------------

// File: rtl/abz_quad_decoder.sv
// abz_quad_decoder: quadrature (A/B/Z) encoder position decoder.
//
// Purpose:
//   Turns the asynchronous A/B/Z encoder lines into a position count. It
//   supports x1/x2/x4 decoding, wrap at CNT_MAX, Z-index loading (continuous
//   or one-shot homing), an init load, a count snapshot and a sticky flag for
//   illegal transitions.
//
// Ports:
//   CLK, RST           clock; synchronous active-high reset
//   A_IN, B_IN, Z_IN   asynchronous encoder inputs
//   MODE               00 = x1, 01 = x2, 1x = x4
//   Z_MODE             0 = load on every qualified Z, 1 = one-shot homing
//   ARM_IN             rising edge arms one-shot homing
//   EN_INIT_IN         rising edge loads INIT_COUNT
//   INIT_COUNT         value loaded by EN_INIT_IN
//   POS_OFFSET         value loaded on a Z load
//   CNT_MAX            wrap limit of the count
//   LATCH_IN           rising edge takes a snapshot of the count
//   ERR_CLR            level; clears ERR
//   CNT_OUT            live position
//   LATCHED_CNT_OUT    snapshot value; LATCH_VLD pulses for one cycle with it
//   Z_LATCHED_CNT      count value just before the most recent Z load
//   DIR_OUT            last direction (1 = up)
//   HOMED              one-shot homing has completed
//   ERR                sticky flag for an illegal A/B transition
//   WRAP_UP, WRAP_DN   one-cycle wrap pulses
module abz_quad_decoder #(
  parameter int BIT_LENGTH = 16,
  parameter int FILT_LEN   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_IN,
  input  logic                  B_IN,
  input  logic                  Z_IN,
  input  logic [1:0]            MODE,
  input  logic                  Z_MODE,
  input  logic                  ARM_IN,
  input  logic                  EN_INIT_IN,
  input  logic [BIT_LENGTH-1:0] INIT_COUNT,
  input  logic [BIT_LENGTH-1:0] POS_OFFSET,
  input  logic [BIT_LENGTH-1:0] CNT_MAX,
  input  logic                  LATCH_IN,
  input  logic                  ERR_CLR,
  output logic [BIT_LENGTH-1:0] CNT_OUT,
  output logic [BIT_LENGTH-1:0] LATCHED_CNT_OUT,
  output logic                  LATCH_VLD,
  output logic [BIT_LENGTH-1:0] Z_LATCHED_CNT,
  output logic                  DIR_OUT,
  output logic                  HOMED,
  output logic                  ERR,
  output logic                  WRAP_UP,
  output logic                  WRAP_DN
);

  // Bit order in the 3-bit vectors: [0] = A, [1] = B, [2] = Z.
  logic [2:0] sync1, sync2;
  logic [2:0] flt;
  logic [2:0] flt_q, flt_qq;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {Z_IN, B_IN, A_IN};
      sync2 <= sync1;
    end
  end

  // The glitch filter adopts a new level only after FILT_LEN consecutive
  // cycles of that level. Any return to the current level restarts the run.
  if (FILT_LEN == 0) begin : g_nofilt
    assign flt = sync2;
  end else begin : g_filt
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [CW-1:0] run_cnt;
      logic          lvl;
      always_ff @(posedge CLK) begin
        if (RST) begin
          run_cnt <= '0;
          lvl     <= 1'b0;
        end else if (sync2[i] == lvl) begin
          run_cnt <= '0;
        end else if (run_cnt == CW'(FILT_LEN - 1)) begin
          lvl     <= sync2[i];
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end
      assign flt[i] = lvl;
    end
  end

  logic en_prev, arm_prev, latch_prev, hist_vld, armed;

  // Edge detection uses a registered copy of the filtered levels. This extra
  // stage places the count update FILT_LEN+3 edges after the input is first
  // sampled.
  logic a_lvl, b_lvl, a_edge, b_edge, illegal, x4_evt, x4_up;
  logic z_rise, z_fall, qual_z, z_load;
  logic step_en, step_up;
  logic init_rise, arm_rise, latch_rise;

  assign a_lvl   = flt_q[0];
  assign b_lvl   = flt_q[1];
  assign a_edge  = flt_q[0] ^ flt_qq[0];
  assign b_edge  = flt_q[1] ^ flt_qq[1];
  assign illegal = a_edge & b_edge;
  assign x4_evt  = a_edge ^ b_edge;
  // An A edge counts up when the new A and B differ. A B edge counts up when
  // they match.
  assign x4_up   = a_edge ? (a_lvl ^ b_lvl) : ~(a_lvl ^ b_lvl);

  always_comb begin
    step_en = 1'b0;
    step_up = 1'b0;
    case (MODE)
      2'b00: begin
        step_en = a_edge & ~b_edge & ~b_lvl;
        step_up = a_lvl;
      end
      2'b01: begin
        step_en = a_edge & ~b_edge;
        step_up = x4_up;
      end
      default: begin
        step_en = x4_evt;
        step_up = x4_up;
      end
    endcase
  end

  assign z_rise = flt_q[2] & ~flt_qq[2];
  assign z_fall = ~flt_q[2] & flt_qq[2];
  assign qual_z = DIR_OUT ? z_rise : z_fall;
  assign z_load = qual_z & (~Z_MODE | armed);

  // hist_vld blocks false rising edges on the first cycle after reset when a
  // synchronous control input is already high.
  assign init_rise  = EN_INIT_IN & ~en_prev & hist_vld;
  assign arm_rise   = ARM_IN & ~arm_prev & hist_vld;
  assign latch_rise = LATCH_IN & ~latch_prev & hist_vld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      flt_q           <= '0;
      flt_qq          <= '0;
      en_prev         <= 1'b0;
      arm_prev        <= 1'b0;
      latch_prev      <= 1'b0;
      hist_vld        <= 1'b0;
      armed           <= 1'b0;
      CNT_OUT         <= '0;
      LATCHED_CNT_OUT <= '0;
      LATCH_VLD       <= 1'b0;
      Z_LATCHED_CNT   <= '0;
      DIR_OUT         <= 1'b0;
      HOMED           <= 1'b0;
      ERR             <= 1'b0;
      WRAP_UP         <= 1'b0;
      WRAP_DN         <= 1'b0;
    end else begin
      flt_q      <= flt;
      flt_qq     <= flt_q;
      en_prev    <= EN_INIT_IN;
      arm_prev   <= ARM_IN;
      latch_prev <= LATCH_IN;
      hist_vld   <= 1'b1;
      WRAP_UP    <= 1'b0;
      WRAP_DN    <= 1'b0;
      LATCH_VLD  <= latch_rise;

      if (latch_rise) LATCHED_CNT_OUT <= CNT_OUT;
      if (x4_evt)     DIR_OUT <= x4_up;

      if (illegal)      ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;

      if (init_rise) begin
        CNT_OUT <= INIT_COUNT;
      end else if (z_load) begin
        CNT_OUT       <= POS_OFFSET;
        Z_LATCHED_CNT <= CNT_OUT;
        if (Z_MODE) begin
          armed <= 1'b0;
          HOMED <= 1'b1;
        end
      end else if (step_en) begin
        if (step_up) begin
          if (CNT_OUT >= CNT_MAX) begin
            CNT_OUT <= '0;
            WRAP_UP <= 1'b1;
          end else begin
            CNT_OUT <= CNT_OUT + BIT_LENGTH'(1);
          end
        end else begin
          if (CNT_OUT == '0) begin
            CNT_OUT <= CNT_MAX;
            WRAP_DN <= 1'b1;
          end else begin
            CNT_OUT <= CNT_OUT - BIT_LENGTH'(1);
          end
        end
      end

      // A re-arm that lands on the same cycle as a homing load wins, so the
      // request is never lost.
      if (arm_rise) begin
        armed <= 1'b1;
        HOMED <= 1'b0;
      end
    end
  end

endmodule
